load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT, default 16, meaning: maximum number of ACCESS cycles without mem_ack before a bus error is reported.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 clk  in  1  system clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 start  in  1  one-cycle request pulse from control unit; sampled only in IDLE.
REQ-006 is_store  in  1  1 = store, 0 = load.
REQ-007 funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 addr  in  32  effective address (ALU result).
REQ-009 wdata  in  32  store data (rs2 value).
REQ-010 busy  out  1  high from the cycle after start until done.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 rdata  out  32  extended load result, valid while done=1 and held until the next accepted start.
REQ-013 err  out  2  valid with done: 00 ok, 01 misaligned/illegal funct3, 10 timeout.
REQ-014 mem_req, mem_we  out  1,1  bus request and write enable.
REQ-015 mem_addr  out  32  {addr[31:2],2'b00}.
REQ-016 mem_be  out  4  byte enables; mem_wdata  out  32  lane-replicated store data.
REQ-017 mem_ack  in  1; mem_rdata  in  32  bus acknowledge and read word.

Function
REQ-018 The FSM SHALL have three states: IDLE, ACCESS and RESP.
REQ-019 IDLE + start: latch all inputs; if illegal, go to RESP with err=01, otherwise go to ACCESS.
REQ-020 An access SHALL be illegal when H/HU has addr[0]=1, W has addr[1:0]!=0, store funct3 is not 000/001/010, or load funct3 is 011/110/111; no mem_req is issued.
REQ-021 In ACCESS, mem_req, mem_we, mem_addr, mem_be and mem_wdata SHALL be registered outputs, stable until ack.
REQ-022 ACCESS + mem_ack: capture mem_rdata, go to RESP with err=00; mem_req deasserts in the RESP cycle.
REQ-023 ACCESS with no ack for TIMEOUT cycles: go to RESP with err=10 and leave rdata unchanged.
REQ-024 An ack arriving in the same cycle as the timeout SHALL win (err=00).
REQ-025 RESP: done=1 for exactly one cycle, then IDLE; busy=0 in IDLE only.
REQ-026 start while busy SHALL be ignored and not queued.
REQ-027 Latency: start at cycle 0, mem_req at cycle 1, ack at cycle k>=1, done at k+1; an illegal access gives done at cycle 1.
REQ-028 mem_be: B 0001<<addr[1:0]; H 0011<<addr[1:0]; W 1111.
REQ-029 mem_wdata: B {4{wdata[7:0]}}; H {2{wdata[15:0]}}; W wdata.
REQ-030 Load extraction: select the lane by addr[1:0]; B/H sign-extend; BU/HU zero-extend; W pass-through.
REQ-031 Store completion SHALL leave rdata unchanged.

Reset
REQ-032 rst_n low SHALL immediately force IDLE and set busy, done, mem_req and mem_we to 0, err to 00, and rdata, mem_addr, mem_be and mem_wdata to 0.
REQ-033 Reset during ACCESS SHALL abort the access (mem_req drops asynchronously); no done is produced for it.
REQ-034 The first start is accepted on the first rising edge after rst_n rises.

Structure
REQ-035 A shared package SHALL hold the funct3 encodings, the err codes and the state encoding.
REQ-036 A combinational sub-module lsu_align SHALL generate mem_be/mem_wdata and perform load extraction and extension.
REQ-037 The timeout counter SHALL be $clog2(TIMEOUT)+1 bits wide, cleared on entry to ACCESS.

Verification
REQ-038 LB, addr=0x103, mem_rdata=0x80FF_1234, ack at cycle 2 -> mem_addr=0x100, mem_be=1000, done at cycle 3, rdata=0xFFFF_FF80, err=00.
REQ-039 SH, addr=0x22, wdata=0x0000_ABCD -> mem_we=1, mem_be=1100, mem_wdata=0xABCD_ABCD, done after ack, rdata unchanged.
REQ-040 LW, addr=0x06 -> no mem_req, done at cycle 1, err=01; LHU, addr=0x02, mem_rdata=0x8001_0000 -> rdata=0x0000_8001.
REQ-041 LW with ack withheld, TIMEOUT=16 -> mem_req high for 16 cycles, then done with err=10; ack on cycle 16 -> err=00.
REQ-042 rst_n pulsed low in ACCESS -> mem_req and busy 0 immediately, no done; a new LBU afterwards completes normally.
REQ-043 A second start while busy -> ignored; exactly one done is produced.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: funct3 access sizes, error codes,
// FSM states and the legality check applied when a request is accepted.
package load_store_unit_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_ILLEGAL = 2'b01,
        ERR_TIMEOUT = 2'b10
    } err_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_t;

    // Unsigned variants exist only for loads; anything unlisted is illegal.
    function automatic logic lsu_illegal(input logic is_store, input logic [2:0] f3,
                                         input logic [1:0] addr_lo);
        logic bad;
        case (f3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = addr_lo[0];
            F3_W:    bad = (addr_lo != 2'b00);
            F3_BU:   bad = is_store;
            F3_HU:   bad = is_store | addr_lo[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Memory bus between the load/store unit (master) and the memory (slave).
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                    input  mem_ack, mem_rdata);
    modport slave  (input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                    output mem_ack, mem_rdata);
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables and replicated store data for the
// request, lane selection plus sign/zero extension for the load response.
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] load_data
);

    logic [15:0] lane;

    always_comb begin
        lane      = 16'(mem_rdata >> {addr_lo, 3'b000});
        be        = 4'b1111;
        wdata_rep = wdata;
        load_data = mem_rdata;
        case (funct3[1:0])
            2'b00: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            2'b01: begin
                be        = 4'b0011 << addr_lo;
                wdata_rep = {2{wdata[15:0]}};
            end
            default: ;
        endcase
        case (funct3)
            F3_B:    load_data = {{24{lane[7]}}, lane[7:0]};
            F3_BU:   load_data = {24'h0, lane[7:0]};
            F3_H:    load_data = {{16{lane[15]}}, lane[15:0]};
            F3_HU:   load_data = {16'h0, lane[15:0]};
            default: load_data = mem_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: IDLE -> ACCESS -> RESP, with illegal
// requests short-circuiting to RESP and a bounded wait for the memory ack.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic [1:0]  err,
    load_store_unit_if.master mem
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    state_t      state;
    logic        is_store_q;
    logic [2:0]  funct3_q;
    logic [1:0]  addr_lo_q;
    logic [CW-1:0] tmo_cnt;

    logic [2:0]  al_funct3;
    logic [1:0]  al_addr_lo;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_ldata;

    // Raw inputs drive the aligner while a request is being accepted; the
    // latched copies drive it afterwards for load extraction.
    assign al_funct3  = (state == ST_IDLE) ? funct3    : funct3_q;
    assign al_addr_lo = (state == ST_IDLE) ? addr[1:0] : addr_lo_q;

    lsu_align u_align (
        .funct3    (al_funct3),
        .addr_lo   (al_addr_lo),
        .wdata     (wdata),
        .mem_rdata (mem.mem_rdata),
        .be        (al_be),
        .wdata_rep (al_wdata),
        .load_data (al_ldata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            is_store_q    <= 1'b0;
            funct3_q      <= 3'b000;
            addr_lo_q     <= 2'b00;
            tmo_cnt       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            rdata         <= 32'h0;
            err           <= ERR_OK;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= 32'h0;
            mem.mem_be    <= 4'h0;
            mem.mem_wdata <= 32'h0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: if (start) begin
                    is_store_q <= is_store;
                    funct3_q   <= funct3;
                    addr_lo_q  <= addr[1:0];
                    busy       <= 1'b1;
                    if (lsu_illegal(is_store, funct3, addr[1:0])) begin
                        state <= ST_RESP;
                        err   <= ERR_ILLEGAL;
                        done  <= 1'b1;
                    end else begin
                        state         <= ST_ACCESS;
                        err           <= ERR_OK;
                        tmo_cnt       <= '0;
                        mem.mem_req   <= 1'b1;
                        mem.mem_we    <= is_store;
                        mem.mem_addr  <= {addr[31:2], 2'b00};
                        mem.mem_be    <= al_be;
                        mem.mem_wdata <= al_wdata;
                    end
                end
                ST_ACCESS: begin
                    // Ack is tested first so it wins over a coincident timeout.
                    if (mem.mem_ack) begin
                        state       <= ST_RESP;
                        done        <= 1'b1;
                        err         <= ERR_OK;
                        mem.mem_req <= 1'b0;
                        mem.mem_we  <= 1'b0;
                        if (!is_store_q) rdata <= al_ldata;
                    end else if (tmo_cnt == CW'(TIMEOUT - 1)) begin
                        state       <= ST_RESP;
                        done        <= 1'b1;
                        err         <= ERR_TIMEOUT;
                        mem.mem_req <= 1'b0;
                        mem.mem_we  <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a vector table of single accesses plus
// hand sequences for timeout, late ack, reset mid-access and start-while-busy.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, is_store;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        busy, done;
    logic [31:0] rdata;
    logic [1:0]  err;

    int checks = 0;
    int errors = 0;

    load_store_unit_if bus ();

    load_store_unit #(.TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store),
        .funct3(funct3), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
        .rdata(rdata), .err(err), .mem(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] mrd;
        int          k;
        logic        exp_req;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic [31:0] exp_rd;
        logic [1:0]  exp_err;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] mrd, input int k,
                                input logic req, input logic [3:0] be, input logic [31:0] ewd,
                                input logic [31:0] erd, input logic [1:0] eerr);
        vec_t v;
        v.st = st; v.f3 = f3; v.addr = a; v.wd = wd; v.mrd = mrd; v.k = k;
        v.exp_req = req; v.exp_be = be; v.exp_wd = ewd; v.exp_rd = erd; v.exp_err = eerr;
        return v;
    endfunction

    // Caller is just past a clock edge; start is sampled on the next rising edge.
    task automatic run_vec(input vec_t v, input string tag);
        is_store = v.st; funct3 = v.f3; addr = v.addr; wdata = v.wd;
        bus.mem_rdata = v.mrd; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; addr = 32'hFFFF_FFFF; funct3 = 3'b111; wdata = 32'hFFFF_FFFF;
        if (v.exp_req) begin
            for (int c = 1; c <= v.k; c++) begin
                bus.mem_ack = (c == v.k);
                @(negedge clk);
                check({tag, "_req"}, 32'(bus.mem_req), 32'd1);
                check({tag, "_be"}, 32'(bus.mem_be), 32'(v.exp_be));
                if (c == 1) begin
                    check({tag, "_busy"}, 32'(busy), 32'd1);
                    check({tag, "_we"}, 32'(bus.mem_we), 32'(v.st));
                    check({tag, "_addr"}, bus.mem_addr, v.addr & 32'hFFFF_FFFC);
                    check({tag, "_wdata"}, bus.mem_wdata, v.exp_wd);
                    check({tag, "_done_early"}, 32'(done), 32'd0);
                end
                @(posedge clk); #1;
            end
            bus.mem_ack = 1'b0;
        end
        @(negedge clk);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_err"}, 32'(err), 32'(v.exp_err));
        check({tag, "_rdata"}, rdata, v.exp_rd);
        check({tag, "_req_resp"}, 32'(bus.mem_req), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int reqs, got, dones;
        vec_t v;

        vecs[0]  = mk(0, F3_B,  32'h103,  32'h0,        32'h80FF_1234, 2, 1, 4'b1000, 32'h0,        32'hFFFF_FF80, 2'b00);
        vecs[1]  = mk(1, F3_H,  32'h22,   32'h0000_ABCD, 32'h1234_5678, 1, 1, 4'b1100, 32'hABCD_ABCD, 32'hFFFF_FF80, 2'b00);
        vecs[2]  = mk(0, F3_W,  32'h06,   32'h0,        32'h0,         1, 0, 4'b0000, 32'h0,        32'hFFFF_FF80, 2'b01);
        vecs[3]  = mk(0, F3_HU, 32'h02,   32'h0,        32'h8001_0000, 1, 1, 4'b1100, 32'h0,        32'h0000_8001, 2'b00);
        vecs[4]  = mk(0, F3_H,  32'h02,   32'h0,        32'h8001_0000, 3, 1, 4'b1100, 32'h0,        32'hFFFF_8001, 2'b00);
        vecs[5]  = mk(0, F3_BU, 32'h101,  32'h0,        32'h1234_A5C3, 1, 1, 4'b0010, 32'h0,        32'h0000_00A5, 2'b00);
        vecs[6]  = mk(0, F3_B,  32'h100,  32'h0,        32'h0000_007F, 1, 1, 4'b0001, 32'h0,        32'h0000_007F, 2'b00);
        vecs[7]  = mk(1, F3_B,  32'h03,   32'hDEAD_BE5A, 32'hFFFF_FFFF, 2, 1, 4'b1000, 32'h5A5A_5A5A, 32'h0000_007F, 2'b00);
        vecs[8]  = mk(1, F3_W,  32'h1004, 32'hCAFE_F00D, 32'h0,        1, 1, 4'b1111, 32'hCAFE_F00D, 32'h0000_007F, 2'b00);
        vecs[9]  = mk(0, F3_W,  32'h1008, 32'h0,        32'h89AB_CDEF, 1, 1, 4'b1111, 32'h0,        32'h89AB_CDEF, 2'b00);
        vecs[10] = mk(1, F3_H,  32'h21,   32'h0,        32'h0,         1, 0, 4'b0000, 32'h0,        32'h89AB_CDEF, 2'b01);
        vecs[11] = mk(1, F3_BU, 32'h0,    32'h0,        32'h0,         1, 0, 4'b0000, 32'h0,        32'h89AB_CDEF, 2'b01);
        vecs[12] = mk(0, 3'b011, 32'h0,   32'h0,        32'h0,         1, 0, 4'b0000, 32'h0,        32'h89AB_CDEF, 2'b01);
        vecs[13] = mk(0, F3_H,  32'h03,   32'h0,        32'h0,         1, 0, 4'b0000, 32'h0,        32'h89AB_CDEF, 2'b01);

        rst_n = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'b0;
        addr = 32'h0; wdata = 32'h0; bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_req", 32'(bus.mem_req), 32'd0);
        check("rst_we", 32'(bus.mem_we), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_addr", bus.mem_addr, 32'h0);
        check("rst_be", 32'(bus.mem_be), 32'h0);
        check("rst_wdata", bus.mem_wdata, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Ack withheld: 16 request cycles, then timeout with rdata untouched.
        is_store = 1'b0; funct3 = F3_W; addr = 32'h40; bus.mem_rdata = 32'h5555_AAAA;
        start = 1'b1; reqs = 0; got = 0;
        for (int c = 1; c <= 40 && got == 0; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            if (done) begin
                got = 1;
                check("tmo_done_cycle", 32'(c), 32'd17);
                check("tmo_err", 32'(err), 32'd2);
                check("tmo_rdata", rdata, 32'h89AB_CDEF);
            end else if (bus.mem_req) reqs++;
        end
        check("tmo_done_seen", 32'(got), 32'd1);
        check("tmo_req_cycles", 32'(reqs), 32'd16);
        @(posedge clk); #1;

        // Ack on the 16th access cycle beats the timeout.
        is_store = 1'b0; funct3 = F3_W; addr = 32'h44; bus.mem_rdata = 32'h1357_9BDF;
        start = 1'b1; reqs = 0;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            bus.mem_ack = (c == 16);
            @(negedge clk);
            if (bus.mem_req && !done) reqs++;
        end
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        @(negedge clk);
        check("ack16_req_cycles", 32'(reqs), 32'd16);
        check("ack16_done", 32'(done), 32'd1);
        check("ack16_err", 32'(err), 32'd0);
        check("ack16_rdata", rdata, 32'h1357_9BDF);
        @(posedge clk); #1;

        // Extra start pulses while busy must be dropped.
        is_store = 1'b0; funct3 = F3_W; addr = 32'h10; bus.mem_rdata = 32'h1122_3344;
        start = 1'b1; dones = 0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            start = (c <= 2);
            if (c <= 2) addr = 32'h20;
            bus.mem_ack = (c == 3);
            @(negedge clk);
            if (done) dones++;
            if (c == 3) check("busy_start_addr", bus.mem_addr, 32'h10);
        end
        bus.mem_ack = 1'b0; start = 1'b0;
        check("busy_start_dones", 32'(dones), 32'd1);
        check("busy_start_rdata", rdata, 32'h1122_3344);
        check("busy_start_idle", 32'(busy), 32'd0);
        @(posedge clk); #1;

        // Reset in ACCESS: request drops immediately, no completion follows.
        is_store = 1'b0; funct3 = F3_W; addr = 32'h80; bus.mem_rdata = 32'hFFFF_0000;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("rsta_req_before", 32'(bus.mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rsta_req", 32'(bus.mem_req), 32'd0);
        check("rsta_busy", 32'(busy), 32'd0);
        dones = 0;
        bus.mem_ack = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (c == 2) begin rst_n = 1'b1; bus.mem_ack = 1'b0; end
            @(negedge clk);
            if (done) dones++;
        end
        check("rsta_no_done", 32'(dones), 32'd0);
        check("rsta_rdata", rdata, 32'h0);
        @(posedge clk); #1;
        v = mk(0, F3_BU, 32'h2, 32'h0, 32'h00FE_0000, 2, 1, 4'b0100, 32'h0, 32'h0000_00FE, 2'b00);
        run_vec(v, "post_rst_lbu");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
